bus_slave_responder: RTL and testbench
======================================

# bus_slave_responder

Generic bus slave for the shared bus: it receives the address, address strobe, read/write and write data that the bus master multiplexer drives. It answers with read data and an active-low ready after a programmable number of wait states, and backs the accesses with an internal 32-bit register bank. It sits behind the address decoder, which provides its chip select. Its `rd_data`/`rdy_` outputs feed the slave-side return multiplexer toward the masters.

## Interface
- `WAIT_CYCLES`, default 2: wait states inserted between request acceptance and acknowledge (0–15).
- `REG_AW`, default 4: register bank word-address width; bank depth is 2^REG_AW words of 32 bits.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `cs_`  in  1  chip select from the address decoder, active low.
- `as_`  in  1  address strobe from the shared bus, active low.
- `rw`  in  1  `READ` (1) / `WRITE` (0).
- `addr`  in  30  word address; only `addr[REG_AW-1:0]` is used, upper bits are ignored (aliasing).
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data; 0 whenever `rdy_` is high.
- `rdy_`  out  1  transfer complete, active low, one-cycle pulse.

## Operation
- **Request:** `cs_`=0 and `as_`=0, both sampled at a rising edge.
- **State machine:** IDLE, WAIT, ACK.
  - IDLE → WAIT on a request when `WAIT_CYCLES`>0. Latch `addr[REG_AW-1:0]`, `rw` and `wr_data`, and load the counter with `WAIT_CYCLES`.
  - IDLE → ACK on a request when `WAIT_CYCLES`=0. Latch the same request fields.
  - WAIT: the counter decrements each cycle. When it would reach 0 → ACK.
  - WAIT → IDLE (abort) if `cs_` or `as_` is sampled high. No write occurs and `rdy_` is not asserted.
  - ACK → IDLE unconditionally after one cycle.
- **Write:** the bank word at the latched address is updated on the edge that enters ACK.
- **Read:** `rd_data` is registered from the bank on the edge that enters ACK and held for the ACK cycle only.
- **In ACK:** `rdy_`=0 for exactly one cycle. The latched request is used, not the live bus inputs.
- **Back-to-back:** the master drops `as_` after seeing `rdy_`. If `as_`/`cs_` are still low in the cycle after ACK, IDLE treats them as a new request.
- **Read-after-write:** a read of the same address immediately after a write returns the new value.
- **Reset** (any time, including mid-transfer): state = IDLE, counter = 0, `rdy_`=1, `rd_data`=0, all bank words = 0. Any in-flight write is discarded.

## Timing
- The request is present in cycle 0 and sampled at the end of cycle 0.
- `rdy_`=0 during cycle `WAIT_CYCLES`+1. This gives latency `WAIT_CYCLES`+1 from request to acknowledge.
- Minimum request-to-request spacing is `WAIT_CYCLES`+2 cycles (acknowledge cycle plus the IDLE sampling cycle).
- `rd_data` is valid exactly in the cycle where `rdy_`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`BUS_SLAVE_WAIT_EN` defined:** the WAIT state and counter are built, and `WAIT_CYCLES` applies as described.
- **`BUS_SLAVE_WAIT_EN` undefined:** no WAIT state and no counter. `WAIT_CYCLES` is ignored, and every request goes IDLE → ACK with `rdy_`=0 in cycle 1.

## Test plan
- **Reset:** assert `reset` mid-WAIT with a write to addr 3 pending → `rdy_`=1 and `rd_data`=0 immediately. Reading addr 3 later returns 0.
- **Write then read** (`WAIT_CYCLES`=2): write 0xDEADBEEF to addr 5 in cycle 0 → `rdy_` low only in cycle 3. Then read addr 5 → `rdy_` low 3 cycles after the request, with `rd_data`=0xDEADBEEF in that cycle and 0 otherwise.
- **Aliasing** (`REG_AW`=4): write 0x12345678 to addr 0x15 → a read of addr 0x5 returns 0x12345678.
- **Abort:** issue a write of 0xAAAA5555 to addr 2, then deassert `as_` in cycle 1 → no `rdy_` pulse. A subsequent read of addr 2 returns the prior value.
- **Chip select gating:** `as_`=0 with `cs_`=1 for 10 cycles → `rdy_` stays high and the bank is unchanged.
- **Macro off:** build without `BUS_SLAVE_WAIT_EN` and `WAIT_CYCLES`=5; read addr 0 → `rdy_` low in cycle 1. Keep `as_` low continuously → `rdy_` pulses every 2 cycles.

Source files
------------

// File: rtl/bus_slave_responder.sv
// Shared-bus slave with a 2^REG_AW x 32 register bank and an active-low ready after wait states.
// Define BUS_SLAVE_WAIT_EN to build the WAIT state and counter; otherwise every request acks in one cycle.
module bus_slave_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned REG_AW      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_
);

  localparam int unsigned Depth = 1 << REG_AW;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAck  = 2'd2;
`ifdef BUS_SLAVE_WAIT_EN
  localparam logic [1:0] StWait = 2'd1;
`endif

  logic [1:0]        state_q, state_d;
  logic [31:0]       bank_q [Depth];
  logic [31:0]       bank_d [Depth];
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rdy_q, rdy_d;
  logic              req;
  logic              enter_ack;
  logic [REG_AW-1:0] acc_addr;
  logic              acc_rw;
  logic [31:0]       acc_wdata;
  logic              unused_bits;

  assign req = !cs_ && !as_;

`ifdef BUS_SLAVE_WAIT_EN
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [31:0]       wdata_q, wdata_d;

  assign unused_bits = ^addr[29:REG_AW];

  // A zero-wait request acks on the sampling edge, so it must use the live bus fields.
  assign acc_addr  = (state_q == StIdle) ? addr[REG_AW-1:0] : addr_q;
  assign acc_rw    = (state_q == StIdle) ? rw : rw_q;
  assign acc_wdata = (state_q == StIdle) ? wr_data : wdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    enter_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = addr[REG_AW-1:0];
          rw_d    = rw;
          wdata_d = wr_data;
          if (WAIT_CYCLES == 0) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WAIT_CYCLES[3:0];
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d   = StAck;
          cnt_d     = '0;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end
`else
  assign unused_bits = ^{addr[29:REG_AW], WAIT_CYCLES[0]};

  assign acc_addr  = addr[REG_AW-1:0];
  assign acc_rw    = rw;
  assign acc_wdata = wr_data;

  always_comb begin
    state_d   = StIdle;
    enter_ack = 1'b0;
    if (state_q == StIdle && req) begin
      state_d   = StAck;
      enter_ack = 1'b1;
    end
  end
`endif

  always_comb begin
    bank_d = bank_q;
    if (enter_ack && !acc_rw) begin
      bank_d[acc_addr] = acc_wdata;
    end
  end

  // Reads see the bank as of the previous edge, which already holds any earlier write.
  assign rd_data_d = (enter_ack && acc_rw) ? bank_q[acc_addr] : '0;
  assign rdy_d     = !enter_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_data_q <= '0;
      rdy_q     <= 1'b1;
      for (int i = 0; i < int'(Depth); i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      rdy_q     <= rdy_d;
      bank_q    <= bank_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed self-checking bench for bus_slave_responder; follows BUS_SLAVE_WAIT_EN for expected latency.
module tb_bus_slave_responder;

`ifdef BUS_SLAVE_WAIT_EN
  localparam int WC  = 2;
  localparam int LAT = WC;
`else
  localparam int WC  = 5;
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        reset;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  int n_cmp;
  int n_err;

  bus_slave_responder #(
    .WAIT_CYCLES(WC),
    .REG_AW     (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cs_    (cs_),
    .as_    (as_),
    .rw     (rw),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .rdy_   (rdy_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    cs_ = 1'b1;
    as_ = 1'b1;
  endtask

  // Request in cycle 0; check every cycle through the following IDLE cycle.
  task automatic xfer(input logic r, input logic [29:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input string name);
    logic        exp_rdy;
    logic [31:0] exp_rdd;
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = wd;
    for (int n = 1; n <= LAT + 2; n++) begin
      @(posedge clk); #1;
      exp_rdy = (n == LAT + 1) ? 1'b0 : 1'b1;
      exp_rdd = (n == LAT + 1 && r) ? exp_rd : 32'h0;
      n_cmp++;
      if (rdy_ !== exp_rdy) begin
        n_err++;
        $display("FAIL %s rdy_ cycle %0d: got %b want %b", name, n, rdy_, exp_rdy);
      end
      n_cmp++;
      if (rd_data !== exp_rdd) begin
        n_err++;
        $display("FAIL %s rd_data cycle %0d: got %h want %h", name, n, rd_data, exp_rdd);
      end
      if (n == LAT + 1) bus_idle();
    end
    bus_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rdy_ !== 1'b1 || rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_init: got rdy_=%b rd_data=%h want 1/0", rdy_, rd_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(1'b0, 30'd3, 32'h1111_2222, 32'h0, "rst_seed_wr");
    // Reset asserted during the ack of a read must clear the outputs at once.
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 30'd3;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rdy_ !== 1'b1 || rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_in_ack: got rdy_=%b rd_data=%h want 1/0", rdy_, rd_data);
    end
    bus_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    // Write pending in the first cycle, then reset.
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd4; wr_data = 32'h5555_6666;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rdy_ !== 1'b1 || rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got rdy_=%b rd_data=%h want 1/0", rdy_, rd_data);
    end
    bus_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(1'b1, 30'd3, 32'h0, 32'h0, "rst_rd3");
    xfer(1'b1, 30'd4, 32'h0, 32'h0, "rst_rd4");
  endtask

  task automatic test_write_read();
    xfer(1'b0, 30'd5, 32'hDEAD_BEEF, 32'h0, "wr5");
    xfer(1'b1, 30'd5, 32'h0, 32'hDEAD_BEEF, "rd5");
  endtask

  task automatic test_raw();
    xfer(1'b0, 30'd7, 32'hCAFE_F00D, 32'h0, "raw_wr7");
    xfer(1'b1, 30'd7, 32'h0, 32'hCAFE_F00D, "raw_rd7");
    xfer(1'b0, 30'd7, 32'h0102_0304, 32'h0, "raw_wr7b");
    xfer(1'b1, 30'd7, 32'h0, 32'h0102_0304, "raw_rd7b");
  endtask

  task automatic test_alias();
    xfer(1'b0, 30'h15, 32'h1234_5678, 32'h0, "alias_wr15");
    xfer(1'b1, 30'h5, 32'h0, 32'h1234_5678, "alias_rd5");
    xfer(1'b1, 30'h3FFF_FFF5, 32'h0, 32'h1234_5678, "alias_rd_hi");
  endtask

`ifdef BUS_SLAVE_WAIT_EN
  task automatic test_abort();
    xfer(1'b0, 30'd2, 32'h0BAD_F00D, 32'h0, "abort_seed");
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd2; wr_data = 32'hAAAA_5555;
    @(posedge clk); #1;
    as_ = 1'b1;
    for (int n = 2; n <= LAT + 3; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rdy_ !== 1'b1) begin
        n_err++;
        $display("FAIL abort rdy_ cycle %0d: got %b want 1", n, rdy_);
      end
    end
    bus_idle();
    xfer(1'b1, 30'd2, 32'h0, 32'h0BAD_F00D, "abort_rd2");
  endtask
`endif

  task automatic test_cs_gating();
    cs_ = 1'b1; as_ = 1'b0; rw = 1'b0; addr = 30'd5; wr_data = 32'hFFFF_FFFF;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rdy_ !== 1'b1) begin
        n_err++;
        $display("FAIL cs_gate rdy_ cycle %0d: got %b want 1", n, rdy_);
      end
    end
    bus_idle();
    @(posedge clk); #1;
    xfer(1'b1, 30'd5, 32'h0, 32'h1234_5678, "cs_gate_rd5");
  endtask

  task automatic test_back_to_back();
    logic        exp_rdy;
    logic [31:0] exp_rdd;
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 30'd7;
    for (int n = 1; n <= 3 * (LAT + 2); n++) begin
      @(posedge clk); #1;
      exp_rdy = ((n % (LAT + 2)) == LAT + 1) ? 1'b0 : 1'b1;
      exp_rdd = exp_rdy ? 32'h0 : 32'h0102_0304;
      n_cmp++;
      if (rdy_ !== exp_rdy || rd_data !== exp_rdd) begin
        n_err++;
        $display("FAIL b2b cycle %0d: got rdy_=%b rd_data=%h want %b/%h",
                 n, rdy_, rd_data, exp_rdy, exp_rdd);
      end
    end
    bus_idle();
    @(posedge clk); #1;
    xfer(1'b1, 30'd0, 32'h0, 32'h0, "rd_addr0");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    rw = 1'b1;
    addr = '0;
    wr_data = '0;
    bus_idle();
    #2;
    test_reset();
    test_write_read();
    test_raw();
    test_alias();
`ifdef BUS_SLAVE_WAIT_EN
    test_abort();
`endif
    test_cs_gating();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
